agtb2_sweep_ctrl: RTL and testbench
===================================

AGTB2_SWEEP_CTRL -- requirements
Module: agtb2_sweep_ctrl

Interface
REQ-001 SHALL provide parameter: SETTLE_CYC, 2, idle cycles between driving a vector and sampling the comparator result (legal 0..15).
REQ-002 SHALL provide port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: start  input  1  request a full sweep, sampled on rising edge.
REQ-005 SHALL provide port: agtb_in  input  1  result from the external 2-bit a>b comparator under control.
REQ-006 SHALL provide port: a_out  output  2  operand a driven to comparator.
REQ-007 SHALL provide port: b_out  output  2  operand b driven to comparator.
REQ-008 SHALL provide port: busy  output  1  high while a sweep is in progress.
REQ-009 SHALL provide port: done  output  1  one-cycle pulse at sweep completion.
REQ-010 SHALL provide port: pass  output  1  high when the last completed sweep had zero mismatches.
REQ-011 SHALL provide port: err_count  output  5  mismatch count of current/last sweep (0..16).
REQ-012 SHALL provide port: first_err_valid  output  1  at least one mismatch recorded.
REQ-013 SHALL provide port: first_err_a  output  2  a operand of first mismatch.
REQ-014 SHALL provide port: first_err_b  output  2  b operand of first mismatch.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK, DONE; all outputs registered.
REQ-016 SHALL keep a 4-bit vector index idx; a_out = idx[3:2], b_out = idx[1:0] in DRIVE/WAIT/CHECK; a_out = b_out = 0 in IDLE and DONE.
REQ-017 IDLE: start=1 -> DRIVE with idx=0, err_count=0, pass=0, first_err_valid=0, first_err_a/b=0; start=0 -> stay.
REQ-018 DRIVE: one cycle; load settle counter; -> WAIT if SETTLE_CYC>0, else -> CHECK.
REQ-019 WAIT: exactly SETTLE_CYC cycles, then -> CHECK.
REQ-020 CHECK: one cycle; sample agtb_in; expected = (a_out > b_out) unsigned; mismatch -> err_count+1, and if first_err_valid=0 capture a_out/b_out into first_err_a/b and set first_err_valid.
REQ-021 CHECK with idx=15 -> DONE; otherwise idx+1 -> DRIVE (no wrap past 15).
REQ-022 DONE: one cycle; done=1; pass = (final err_count==0); -> IDLE.
REQ-023 busy SHALL be 1 in DRIVE, WAIT, CHECK and 0 in IDLE and DONE.
REQ-024 Latency: per vector SETTLE_CYC+2 cycles; done SHALL be high in cycle 16*(SETTLE_CYC+2)+1 after the edge that accepted start (65 for default).
REQ-025 start SHALL be ignored in every state except IDLE (no restart, no queueing).
REQ-026 pass, err_count, first_err_* SHALL hold their values after DONE until the next accepted start.
REQ-027 err_count SHALL not saturate or wrap (max 16 fits 5 bits).

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, idx=0, a_out=b_out=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_a=first_err_b=0, regardless of clk.
REQ-029 Reset mid-sweep SHALL abort without a done pulse; first start after release SHALL run a full 16-vector sweep.

Verification
REQ-030 Ideal comparator model, default SETTLE_CYC, start pulse -> vectors (a,b) 00/00,00/01..11/11 in order, done at cycle 65, pass=1, err_count=0, first_err_valid=0.
REQ-031 agtb_in stuck at 0 -> err_count=6, pass=0, first_err_a=01, first_err_b=00.
REQ-032 agtb_in stuck at 1 -> err_count=10, pass=0, first_err_a=00, first_err_b=00.
REQ-033 start re-pulsed at cycles 10 and 65 of a sweep -> single done at cycle 65, results unchanged, IDLE afterwards.
REQ-034 reset_n low for 3 ns asynchronously during vector idx=7 -> all outputs zero at once, no done; new start -> full sweep, done 65 cycles later.
REQ-035 SETTLE_CYC=0, ideal model -> no WAIT state visited, done at cycle 33, pass=1.

Source files
------------

// File: rtl/agtb2_sweep_ctrl.sv
// Exhaustive sweep controller for an external 2-bit a>b comparator.
// Drives all 16 (a,b) vectors, checks each result and records mismatch statistics.
module agtb2_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       agtb_in,
  output logic [1:0] a_out,
  output logic [1:0] b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       first_err_valid,
  output logic [1:0] first_err_a,
  output logic [1:0] first_err_b
);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

  // WAIT lasts SETTLE_CYC cycles: the counter counts down to zero inclusive
  localparam logic [3:0] SETTLE_LD = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [4:0] err_q, err_d;
  logic       fev_q, fev_d;
  logic [1:0] fa_q, fa_d, fb_q, fb_d;
  logic       mismatch;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    mismatch = agtb_in != (a_q > b_q);
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_DRIVE;
        idx_d   = 4'd0;
        err_d   = 5'd0;
        pass_d  = 1'b0;
        fev_d   = 1'b0;
        fa_d    = 2'd0;
        fb_d    = 2'd0;
      end
      S_DRIVE: begin
        cnt_d   = SETTLE_LD;
        state_d = (SETTLE_CYC > 0) ? S_WAIT : S_CHECK;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 5'd1;
          if (!fev_q) begin
            fev_d = 1'b1;
            fa_d  = a_q;
            fb_d  = b_q;
          end
        end
        // pass becomes visible together with the done pulse
        if (idx_q == 4'hF) begin
          state_d = S_DONE;
          pass_d  = (err_d == 5'd0);
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_DRIVE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    a_d    = busy_d ? idx_d[3:2] : 2'd0;
    b_d    = busy_d ? idx_d[1:0] : 2'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      a_q     <= 2'd0;
      b_q     <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 5'd0;
      fev_q   <= 1'b0;
      fa_q    <= 2'd0;
      fb_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign a_out           = a_q;
  assign b_out           = b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_a     = fa_q;
  assign first_err_b     = fb_q;

endmodule

// File: tb/tb_agtb2_sweep_ctrl.sv
// Bench for agtb2_sweep_ctrl: table of full sweeps against comparator fault models,
// plus restart-ignore and async-reset-abort sequences.
module tb_agtb2_sweep_ctrl;

  typedef struct packed {
    logic [1:0] a, b;
    logic       busy, done, pass;
    logic [4:0] err;
    logic       fev;
    logic [1:0] fa, fb;
  } obs_t;

  typedef struct {
    int sel; int s; int mode; int err; int pass; int fev; int fa; int fb;
  } vec_t;

  localparam int M_IDEAL = 0, M_ST0 = 1, M_ST1 = 2, M_INV = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic agtb0, agtb1;
  obs_t o0, o1, o;
  int   mode = M_IDEAL;
  int   sel_r = 0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  agtb2_sweep_ctrl u0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .agtb_in(agtb0),
    .a_out(o0.a), .b_out(o0.b), .busy(o0.busy), .done(o0.done), .pass(o0.pass),
    .err_count(o0.err), .first_err_valid(o0.fev), .first_err_a(o0.fa), .first_err_b(o0.fb));

  agtb2_sweep_ctrl #(.SETTLE_CYC(0)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .agtb_in(agtb1),
    .a_out(o1.a), .b_out(o1.b), .busy(o1.busy), .done(o1.done), .pass(o1.pass),
    .err_count(o1.err), .first_err_valid(o1.fev), .first_err_a(o1.fa), .first_err_b(o1.fb));

  function automatic logic cmp(input int m, input logic [1:0] a, input logic [1:0] b);
    case (m)
      M_ST0:   return 1'b0;
      M_ST1:   return 1'b1;
      M_INV:   return !(a > b);
      default: return a > b;
    endcase
  endfunction

  assign agtb0 = cmp(mode, o0.a, o0.b);
  assign agtb1 = cmp(mode, o1.a, o1.b);
  always_comb o = (sel_r == 1) ? o1 : o0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v; else start0 = v;
  endtask

  task automatic chk_results(input string tag, input vec_t v);
    chk({tag, "_err"},  o.err,  v.err);
    chk({tag, "_pass"}, o.pass, v.pass);
    chk({tag, "_fev"},  o.fev,  v.fev);
    chk({tag, "_fa"},   o.fa,   v.fa);
    chk({tag, "_fb"},   o.fb,   v.fb);
  endtask

  // Cycle 1 is the period right after the edge that accepts start.
  task automatic run_sweep(input vec_t v, input bit repulse);
    int per, last, bad_seq, bad_post, vi;
    per = v.s + 2;
    last = 16 * per + 1;
    bad_seq = 0;
    bad_post = 0;
    sel_r = v.sel;
    mode = v.mode;
    @(negedge clk);
    set_start(v.sel, 1'b1);
    @(posedge clk); #1;
    set_start(v.sel, 1'b0);
    for (int c = 1; c <= last + 4; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      set_start(v.sel, repulse && (c == 10 || c == last));
      if (c < last) begin
        vi = (c - 1) / per;
        if (o.busy !== 1'b1 || o.done !== 1'b0 ||
            o.a !== 2'(vi >> 2) || o.b !== 2'(vi & 3)) begin
          if (bad_seq == 0)
            $display("FAIL seq cycle=%0d actual a=%0d b=%0d busy=%0d done=%0d expected a=%0d b=%0d busy=1 done=0",
                     c, o.a, o.b, o.busy, o.done, vi >> 2, vi & 3);
          bad_seq++;
        end
      end else if (c == last) begin
        chk("done_at_last", o.done, 1);
        chk("busy_at_last", o.busy, 0);
        chk("ab_at_last", {o.a, o.b}, 0);
        chk_results("res", v);
      end else begin
        if (o.done !== 1'b0 || o.busy !== 1'b0 || {o.a, o.b} !== 4'd0 ||
            o.err != 5'(v.err) || o.pass != 1'(v.pass) || o.fev != 1'(v.fev) ||
            o.fa != 2'(v.fa) || o.fb != 2'(v.fb))
          bad_post++;
      end
    end
    set_start(v.sel, 1'b0);
    chk("vector_sequence_errs", bad_seq, 0);
    chk("post_done_idle_hold_errs", bad_post, 0);
  endtask

  vec_t tbl[6];
  vec_t ideal0;
  vec_t inv0;

  initial begin
    int found, bad;
    tbl[0] = '{sel: 0, s: 2, mode: M_IDEAL, err: 0,  pass: 1, fev: 0, fa: 0, fb: 0};
    tbl[1] = '{sel: 0, s: 2, mode: M_ST0,   err: 6,  pass: 0, fev: 1, fa: 1, fb: 0};
    tbl[2] = '{sel: 0, s: 2, mode: M_ST1,   err: 10, pass: 0, fev: 1, fa: 0, fb: 0};
    tbl[3] = '{sel: 0, s: 2, mode: M_INV,   err: 16, pass: 0, fev: 1, fa: 0, fb: 0};
    tbl[4] = '{sel: 1, s: 0, mode: M_IDEAL, err: 0,  pass: 1, fev: 0, fa: 0, fb: 0};
    tbl[5] = '{sel: 1, s: 0, mode: M_ST0,   err: 6,  pass: 0, fev: 1, fa: 1, fb: 0};
    ideal0 = tbl[0];
    inv0   = tbl[3];

    #12;
    chk("reset_state_u0", o0, 0);
    chk("reset_state_u1", o1, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) run_sweep(tbl[i], 1'b0);

    // start re-pulsed at cycles 10 and 65 must neither restart nor queue a sweep
    run_sweep(ideal0, 1'b1);

    // async reset during vector 7 of a failing sweep
    sel_r = 0;
    mode = M_INV;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (o0.a == 2'd1 && o0.b == 2'd3) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("idx7_reached", found, 1);
    chk("err_before_reset_nonzero", o0.err != 0, 1);
    #1 reset_n = 1'b0;
    #1 chk("async_reset_clears", o0, 0);
    #2 reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (o0.done || o0.busy) bad++;
    end
    chk("no_done_after_abort", bad, 0);
    run_sweep(ideal0, 1'b0);
    run_sweep(inv0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
